traffic_counter_bank: RTL

TRAFFIC_COUNTER_BANK -- requirements
Module: traffic_counter_bank

---
 rtl/traffic_counter_bank.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/traffic_counter_bank.sv
// Per-channel vehicle counter bank: synchronized, debounced detector inputs drive
// decimal (BCD) counters, with a handshaked round-robin snapshot readout.
module traffic_counter_bank #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned DEBOUNCE = 16,
    parameter bit          SATURATE = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [CHANNELS-1:0]          detect,
    input  logic [CHANNELS-1:0]          clear,
    output logic [CHANNELS*4*DIGITS-1:0] count_bcd,
    output logic [CHANNELS-1:0]          overflow,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [2:0]                   rd_chan,
    output logic [4*DIGITS-1:0]          rd_bcd
);

    localparam int unsigned CNT_W = 4 * DIGITS;
    localparam int unsigned DEB_W = 8;
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE - 1);
    localparam logic [2:0]       LAST_CHAN = 3'(CHANNELS - 1);

    typedef enum logic {
        LOAD,
        PRESENT
    } rd_state_t;

    logic [CHANNELS-1:0] sync_meta;
    logic [CHANNELS-1:0] sync_lvl;
    logic [CHANNELS-1:0] filt;
    logic [CHANNELS-1:0] rise_q;
    logic [DEB_W-1:0]    deb_cnt [CHANNELS];
    logic [CNT_W-1:0]    cnt     [CHANNELS];
    logic [CNT_W:0]      inc_res [CHANNELS];

    rd_state_t        state;
    rd_state_t        state_next;
    logic [2:0]       chan_next;
    logic [CNT_W-1:0] bcd_next;
    logic             valid_next;
    logic [CNT_W-1:0] sel_cnt;

    // Decimal increment; the top bit is the carry out of the last digit (all-9s input).
    function automatic logic [CNT_W:0] bcd_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] sum;
        logic             carry;
        sum   = value;
        carry = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (value[d*4 +: 4] >= 4'd9) begin
                    sum[d*4 +: 4] = 4'd0;
                end else begin
                    sum[d*4 +: 4] = value[d*4 +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return {carry, sum};
    endfunction

    // Two-flop synchronizer followed by a disagreement-run debounce filter.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_meta <= '0;
            sync_lvl  <= '0;
            filt      <= '0;
            rise_q    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync_meta <= detect;
            sync_lvl  <= sync_meta;
            for (int i = 0; i < CHANNELS; i++) begin
                rise_q[i] <= 1'b0;
                if (sync_lvl[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_cnt[i] <= '0;
                    filt[i]    <= sync_lvl[i];
                    rise_q[i]  <= sync_lvl[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            inc_res[i] = bcd_inc(cnt[i]);
        end
    end

    // Counters: clear beats a coincident event; overflow is sticky until cleared.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            overflow <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (clear[i]) begin
                    cnt[i]      <= '0;
                    overflow[i] <= 1'b0;
                end else if (rise_q[i]) begin
                    if (inc_res[i][CNT_W]) begin
                        overflow[i] <= 1'b1;
                        if (!SATURATE) begin
                            cnt[i] <= '0;
                        end
                    end else begin
                        cnt[i] <= inc_res[i][CNT_W-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        count_bcd = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            count_bcd[i*CNT_W +: CNT_W] = cnt[i];
        end
    end

    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_chan == 3'(i)) begin
                sel_cnt = cnt[i];
            end
        end
    end

    // Readout: LOAD snapshots the selected count, PRESENT holds it until accepted.
    always_comb begin
        state_next = state;
        chan_next  = rd_chan;
        bcd_next   = rd_bcd;
        valid_next = 1'b0;
        case (state)
            LOAD: begin
                bcd_next   = sel_cnt;
                valid_next = 1'b1;
                state_next = PRESENT;
            end
            PRESENT: begin
                valid_next = 1'b1;
                if (rd_ready) begin
                    valid_next = 1'b0;
                    state_next = LOAD;
                    chan_next  = (rd_chan == LAST_CHAN) ? 3'd0 : rd_chan + 3'd1;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= LOAD;
            rd_chan  <= '0;
            rd_bcd   <= '0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_next;
            rd_chan  <= chan_next;
            rd_bcd   <= bcd_next;
            rd_valid <= valid_next;
        end
    end

endmodule
